fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the project's asynchronous FIFO among `NREQ` producers in the FIFO's write clock domain. Round-robin grants, packet-aware: a grant is held for a burst ending on the requester's `last` flag or after `MAXBURST` words. It drives the FIFO's `winc` and `wdata` and honours `wfull`, so no producer ever sees or handles FIFO back-pressure directly.

## Interface
- `NREQ`, default 4: number of requesters, 2..16.
- `DSIZE`, default 8: data width; matches the FIFO `DSIZE`.
- `MAXBURST`, default 16: maximum words per grant, ≥1.
- `wclk` input 1: write-domain clock; the only clock of the block.
- `wrst_n` input 1: asynchronous, active-low reset.
- `req_valid` input NREQ: per-requester word valid.
- `req_data` input NREQ*DSIZE: requester i occupies bits [i*DSIZE +: DSIZE].
- `req_last` input NREQ: marks the final word of a packet; qualified by valid.
- `req_ready` output NREQ: word accepted this cycle when `req_valid[i] & req_ready[i]`.
- `winc` output 1: FIFO write strobe.
- `wdata` output DSIZE: FIFO write data.
- `wfull` input 1: FIFO full flag (registered in the FIFO).
- `grant_id` output $clog2(NREQ): current or most recent grant owner.
- `busy` output 1: high while in GRANT.

## Operation
- States: IDLE, GRANT.
- IDLE: if any `req_valid`, select the first valid requester searching from `last_gnt+1` modulo NREQ; register it into `grant_id`, clear `beat_cnt`, go to GRANT next cycle. No valid: stay.
- GRANT: transfer = `req_valid[grant_id] & ~wfull`. `winc` = transfer; `wdata` = `req_data[grant_id]`; `req_ready[grant_id]` = `~wfull`; all other ready bits 0. All three are combinational from state, `grant_id`, `wfull`, valid.
- Each transfer increments `beat_cnt` (width $clog2(MAXBURST+1)).
- Burst end: transfer with `req_last[grant_id]`=1, or transfer with `beat_cnt == MAXBURST-1`. On burst end: `last_gnt <= grant_id`, go IDLE.
- Granted requester dropping valid mid-burst: grant is held, no transfer, no timeout.
- `wfull` high in GRANT: stall, no `winc`, no ready, counter frozen; resume the cycle `wfull` falls.
- Valid changes of non-granted requesters have no effect until the next IDLE.
- Reset (any time, including mid-burst): state IDLE, `last_gnt` = NREQ-1 (requester 0 wins first), `grant_id`=0, `beat_cnt`=0; outputs `winc`=0, `req_ready`=0, `busy`=0, `wdata`=0. A partial packet is abandoned; the FIFO keeps words already written.

## Timing
- Arbitration costs exactly one IDLE cycle per grant; burst words then stream at one per cycle.
- Peak throughput: MAXBURST words per MAXBURST+1 cycles.
- Zero-cycle path valid/`wfull` → `winc`/`req_ready`; `wfull` must be a flop output (it is in the FIFO).
- `wdata` equals `req_data[grant_id]` in GRANT and 0 in IDLE.

## Configuration
- `FIFO_ARB_BURST_EN` defined: burst grants as above (`req_last` / MAXBURST end the grant).
- Undefined: every transfer ends the grant (single-word round-robin); `req_last`, `MAXBURST` and `beat_cnt` are ignored and may be optimised out; one idle cycle between words.

## Test plan
- Reset, then requester 2 alone sends 3 words `0x11,0x22,0x33`, last on the third → `winc` on 3 consecutive cycles after 1 idle cycle, FIFO receives 11,22,33, `busy` falls afterwards, `grant_id`=2.
- All 4 requesters valid with 2-word packets → grant order 0,1,2,3,0; each packet contiguous in the FIFO, 3 cycles per packet.
- Requester 1 holds valid with no last for 40 words, MAXBURST=16 → grants of 16,16,8 words; any other valid requester is served between the 16-word chunks.
- `wfull` forced high for 5 cycles mid-burst → `winc` and `req_ready` low for exactly those 5 cycles, no word lost or duplicated, `beat_cnt` unchanged.
- `wrst_n` pulsed low on the 3rd word of a 6-word burst → all outputs 0 asynchronously; next grant goes to requester 0 if valid.
- `FIFO_ARB_BURST_EN` undefined, requesters 0 and 3 continuously valid → FIFO sees alternating 0,3,0,3 words, `winc` on every other cycle.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between NREQ producers, the write arbiter and the async FIFO.
// master: arbiter side; slave: producers/FIFO/testbench side.
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  wfull;
  logic [IDW-1:0]        grant_id;
  logic                  busy;

  modport master (
    input  req_valid, req_data, req_last, wfull,
    output req_ready, winc, wdata, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, req_last, wfull,
    input  req_ready, winc, wdata, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ producers.
// Define FIFO_ARB_BURST_EN for packet bursts (req_last / MAXBURST); otherwise one word per grant.
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int MAXBURST = 16
) (
  input  logic               wclk,
  input  logic               wrst_n,
  fifo_wr_arbiter_if.master  bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int BCW = $clog2(MAXBURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] last_gnt_q, last_gnt_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic [IDW-1:0] pick;
  logic           found;
  logic           xfer;
  logic           burst_end;

`ifndef FIFO_ARB_BURST_EN
  logic unused_last;
  assign unused_last = ^bus.req_last;
`endif

  // Rotating priority: first valid requester after the previous owner.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = last_gnt_q;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_gnt_q) + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    last_gnt_d    = last_gnt_q;
    beat_cnt_d    = beat_cnt_q;
    bus.winc      = 1'b0;
    bus.wdata     = '0;
    bus.req_ready = '0;
    bus.busy      = 1'b0;
    xfer          = 1'b0;
    burst_end     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d = pick;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        bus.busy                  = 1'b1;
        bus.wdata                 = bus.req_data[grant_id_q*DSIZE +: DSIZE];
        bus.req_ready[grant_id_q] = ~bus.wfull;
        xfer                      = bus.req_valid[grant_id_q] & ~bus.wfull;
        bus.winc                  = xfer;
        if (xfer) beat_cnt_d = beat_cnt_q + 1'b1;
`ifdef FIFO_ARB_BURST_EN
        burst_end = xfer & (bus.req_last[grant_id_q] |
                            (beat_cnt_q == BCW'(MAXBURST - 1)));
`else
        burst_end = xfer;
`endif
        // A stalled or idle owner keeps the grant indefinitely.
        if (burst_end) begin
          last_gnt_d = grant_id_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.grant_id = grant_id_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      last_gnt_q <= IDW'(NREQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_gnt_q <= last_gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector table plus reset and burst sequences.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4, DSIZE = 8, MAXBURST = 16;

  logic wclk = 1'b0;
  logic wrst_n;
  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus.master)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_out(input string tag, input logic busy, input logic winc,
                         input logic [7:0] wdata, input logic [3:0] ready, input logic [1:0] gid);
    chk({tag, "_busy"},  32'(bus.busy),      32'(busy));
    chk({tag, "_winc"},  32'(bus.winc),      32'(winc));
    chk({tag, "_wdata"}, 32'(bus.wdata),     32'(wdata));
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'(ready));
    chk({tag, "_gid"},   32'(bus.grant_id),  32'(gid));
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       wfull;
    logic       busy;
    logic       winc;
    logic [7:0] wdata;
    logic [3:0] ready;
    logic [1:0] gid;
  } vec_t;

  vec_t vecs [16];

`ifdef FIFO_ARB_BURST_EN
  logic [8:0] q [NREQ][$];
  logic [7:0] got [$];
  int         gotc [$];
  int         stall_winc, stall_busy;

  task automatic bench_reset();
    for (int r = 0; r < NREQ; r++) q[r].delete();
    got.delete();
    gotc.delete();
    stall_winc = 0;
    stall_busy = 0;
    wrst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.wfull     = 1'b0;
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  task automatic run(input int ncyc, input int full_from, input int full_len);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge wclk);
      for (int r = 0; r < NREQ; r++) begin
        bus.req_valid[r] = (q[r].size() > 0);
        bus.req_data[r*DSIZE +: DSIZE] = (q[r].size() > 0) ? q[r][0][7:0] : 8'h00;
        bus.req_last[r] = (q[r].size() > 0) ? q[r][0][8] : 1'b0;
      end
      bus.wfull = (c >= full_from) && (c < full_from + full_len);
      #1;
      if (bus.winc) begin
        got.push_back(bus.wdata);
        gotc.push_back(c);
      end
      if (bus.wfull) begin
        stall_busy += int'(bus.busy);
        stall_winc += int'(bus.winc | (|bus.req_ready));
      end
      for (int r = 0; r < NREQ; r++)
        if (bus.req_valid[r] && bus.req_ready[r]) void'(q[r].pop_front());
    end
  endtask

  task automatic cmp_log(input string name, input logic [7:0] exp [$]);
    chk({name, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", name, i), 32'(got[i]), 32'(exp[i]));
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Requester data r0..r3 = A0, B1, C2, D3. Every word carries last, so both builds agree.
    vecs[0]  = '{4'b1001, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0};
    vecs[1]  = '{4'b1001, 1'b0, 1'b1, 1'b1, 8'hA0, 4'b0001, 2'd0};
    vecs[2]  = '{4'b1001, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0};
    vecs[3]  = '{4'b1001, 1'b0, 1'b1, 1'b1, 8'hD3, 4'b1000, 2'd3};
    vecs[4]  = '{4'b1001, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd3};
    vecs[5]  = '{4'b1001, 1'b0, 1'b1, 1'b1, 8'hA0, 4'b0001, 2'd0};
    vecs[6]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0};
    vecs[7]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0};
    vecs[8]  = '{4'b0100, 1'b1, 1'b1, 1'b0, 8'hC2, 4'b0000, 2'd2};
    vecs[9]  = '{4'b0100, 1'b1, 1'b1, 1'b0, 8'hC2, 4'b0000, 2'd2};
    vecs[10] = '{4'b0000, 1'b0, 1'b1, 1'b0, 8'hC2, 4'b0100, 2'd2};
    vecs[11] = '{4'b0110, 1'b0, 1'b1, 1'b1, 8'hC2, 4'b0100, 2'd2};
    vecs[12] = '{4'b0110, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd2};
    vecs[13] = '{4'b0110, 1'b0, 1'b1, 1'b1, 8'hB1, 4'b0010, 2'd1};
    vecs[14] = '{4'b0110, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd1};
    vecs[15] = '{4'b0110, 1'b0, 1'b1, 1'b1, 8'hC2, 4'b0100, 2'd2};

    wrst_n        = 1'b0;
    bus.req_valid = '1;
    bus.req_last  = '1;
    bus.req_data  = 32'hD3C2B1A0;
    bus.wfull     = 1'b0;
    repeat (2) @(negedge wclk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0);
    bus.req_valid = '0;
    @(negedge wclk);
    wrst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge wclk);
      bus.req_valid = vecs[i].valid;
      bus.wfull     = vecs[i].wfull;
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].busy, vecs[i].winc, vecs[i].wdata,
              vecs[i].ready, vecs[i].gid);
    end

    // Asynchronous reset while requester 2 holds a stalled grant.
    @(negedge wclk);
    bus.req_valid = 4'b0100;
    bus.wfull     = 1'b0;
    #1;
    chk("pre_rst_idle", 32'(bus.busy), 32'd0);
    @(negedge wclk);
    bus.wfull = 1'b1;
    #1;
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    chk("pre_rst_gid",  32'(bus.grant_id), 32'd2);
    #2;
    wrst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0);
    @(negedge wclk);
    wrst_n        = 1'b1;
    bus.req_valid = 4'b1001;
    bus.wfull     = 1'b0;
    #1;
    chk("post_rst_idle", 32'(bus.busy), 32'd0);
    @(negedge wclk);
    #1;
    chk_out("post_rst_r0", 1'b1, 1'b1, 8'hA0, 4'b0001, 2'd0);

`ifdef FIFO_ARB_BURST_EN
    begin
      logic [7:0] e [$];

      // Lone requester 2, three-word packet.
      bench_reset();
      q[2].push_back({1'b0, 8'h11});
      q[2].push_back({1'b0, 8'h22});
      q[2].push_back({1'b1, 8'h33});
      run(6, 99, 0);
      e = '{8'h11, 8'h22, 8'h33};
      cmp_log("t1", e);
      chk("t1_first_cyc", 32'(gotc[0]), 32'd1);
      chk("t1_last_cyc",  32'(gotc[2]), 32'd3);
      chk("t1_busy_end",  32'(bus.busy), 32'd0);
      chk("t1_gid_end",   32'(bus.grant_id), 32'd2);

      // Four requesters with 2-word packets; requester 0 has a second packet.
      bench_reset();
      for (int r = 0; r < NREQ; r++) begin
        q[r].push_back({1'b0, 8'(r*16 + 1)});
        q[r].push_back({1'b1, 8'(r*16 + 2)});
      end
      q[0].push_back({1'b0, 8'h05});
      q[0].push_back({1'b1, 8'h06});
      run(16, 99, 0);
      e = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h21, 8'h22, 8'h31, 8'h32, 8'h05, 8'h06};
      cmp_log("t2", e);
      chk("t2_cyc1", 32'(gotc[1]), 32'd2);
      chk("t2_cyc2", 32'(gotc[2]), 32'd4);
      chk("t2_cyc9", 32'(gotc[9]), 32'd14);

      // 40-word packet from requester 1 split at MAXBURST, requester 3 interleaved.
      bench_reset();
      for (int i = 0; i < 40; i++) q[1].push_back({(i == 39), 8'(i)});
      q[3].push_back({1'b1, 8'hE0});
      q[3].push_back({1'b1, 8'hE1});
      q[3].push_back({1'b1, 8'hE2});
      run(55, 99, 0);
      e.delete();
      for (int i = 0; i < 16; i++) e.push_back(8'(i));
      e.push_back(8'hE0);
      for (int i = 16; i < 32; i++) e.push_back(8'(i));
      e.push_back(8'hE1);
      for (int i = 32; i < 40; i++) e.push_back(8'(i));
      e.push_back(8'hE2);
      cmp_log("t3", e);

      // wfull held for 5 cycles inside a 20-word packet; counter must freeze.
      bench_reset();
      for (int i = 0; i < 20; i++) q[0].push_back({(i == 19), 8'(8'h40 + i)});
      run(30, 4, 5);
      e.delete();
      for (int i = 0; i < 16; i++) e.push_back(8'(8'h40 + i));
      for (int i = 16; i < 20; i++) e.push_back(8'(8'h40 + i));
      cmp_log("t4", e);
      chk("t4_before_stall", 32'(gotc[2]),  32'd3);
      chk("t4_resume",       32'(gotc[3]),  32'd9);
      chk("t4_chunk_end",    32'(gotc[15]), 32'd21);
      chk("t4_chunk2",       32'(gotc[16]), 32'd23);
      chk("t4_stall_winc",   32'(stall_winc), 32'd0);
      chk("t4_stall_busy",   32'(stall_busy), 32'd5);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
